// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial front end with valid/ready intake.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after bit 0.
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter int   DIV      = 1,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state, nxt;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0] bcnt;
  logic tick, last;
  generate
    if (DIV > 1) begin : g_div
      logic [DW-1:0] dcnt;
      always_ff @(posedge clk or negedge rst)
        if (!rst) dcnt <= '0;
        else dcnt <= (state == IDLE || tick) ? '0 : dcnt + 1'b1;
      assign tick = dcnt == DW'(DIV - 1);
    end else begin : g_nodiv
      assign tick = 1'b1;
    end
  endgenerate
  assign last = (bcnt == BW'(WIDTH - 1)) && tick;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = din_valid ? SHIFT : IDLE;
`ifdef BIT_SERIALIZER_PARITY_EN
      SHIFT:   nxt = last ? PAR : SHIFT;
      PAR:     nxt = tick ? IDLE : PAR;
`else
      SHIFT:   nxt = last ? IDLE : SHIFT;
`endif
      default: nxt = IDLE;
    endcase
  end
  assign din_ready = state == IDLE;
  assign busy      = !din_ready;
  assign out_valid = busy;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic par;
  always_ff @(posedge clk or negedge rst)
    if (!rst) par <= 1'b0;
    else if (din_ready && din_valid) par <= ^din;
  assign out = state == SHIFT ? sh[WIDTH-1] : state == PAR ? par : IDLE_LVL;
`else
  assign out = state == SHIFT ? sh[WIDTH-1] : IDLE_LVL;
`endif
  // bcnt holds at its terminal value; it is only cleared by the next load
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh   <= '0;
      bcnt <= '0;
      done <= 1'b0;
    end else begin
      done <= busy && nxt == IDLE;
      if (din_ready && din_valid) begin
        sh   <= din;
        bcnt <= '0;
      end else if (state == SHIFT && tick) begin
        sh   <= {sh[WIDTH-2:0], 1'b0};
        bcnt <= last ? bcnt : bcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed + random checks of bit_serializer at DIV=1 and DIV=3.
module tb_bit_serializer;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] din1 = '0, din3 = '0;
  logic dv1 = 1'b0, dv3 = 1'b0;
  logic rdy1, out1, ov1, busy1, done1;
  logic rdy3, out3, ov3, busy3, done3;
  int checks = 0, errors = 0;
  bit obs[$];

  bit_serializer #(.WIDTH(8), .DIV(1), .IDLE_LVL(1'b1)) d1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .out(out1), .out_valid(ov1), .busy(busy1), .done(done1));
  bit_serializer #(.WIDTH(8), .DIV(3), .IDLE_LVL(1'b1)) d3 (
    .clk(clk), .rst(rst), .din(din3), .din_valid(dv3), .din_ready(rdy3),
    .out(out3), .out_valid(ov3), .busy(busy3), .done(done3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input int div, input logic exp_done, input string tag);
    chk({tag, ".out"},   div == 1 ? out1 : out3, 8'd1);
    chk({tag, ".ov"},    div == 1 ? ov1 : ov3, 8'd0);
    chk({tag, ".busy"},  div == 1 ? busy1 : busy3, 8'd0);
    chk({tag, ".ready"}, div == 1 ? rdy1 : rdy3, 8'd1);
    chk({tag, ".done"},  div == 1 ? done1 : done3, {7'd0, exp_done});
  endtask

  // Called #1 after the handshake edge; returns #1 into the done cycle.
  task automatic check_word(input int div, input logic [7:0] w, input int inj, input string tag);
    bit e[$];
    for (int b = 7; b >= 0; b--) repeat (div) e.push_back(w[b]);
`ifdef BIT_SERIALIZER_PARITY_EN
    repeat (div) e.push_back(^w);
`endif
    for (int i = 0; i < e.size(); i++) begin
      obs.push_back(div == 1 ? out1 : out3);
      chk($sformatf("%s.bit%0d", tag, i), div == 1 ? out1 : out3, {7'd0, e[i]});
      chk({tag, ".ov"},    div == 1 ? ov1 : ov3, 8'd1);
      chk({tag, ".busy"},  div == 1 ? busy1 : busy3, 8'd1);
      chk({tag, ".ready"}, div == 1 ? rdy1 : rdy3, 8'd0);
      chk({tag, ".done"},  div == 1 ? done1 : done3, 8'd0);
      if (i == inj) begin
        if (div == 1) begin dv1 = 1'b1; din1 = 8'h33; end
        else begin dv3 = 1'b1; din3 = 8'h33; end
      end
      @(posedge clk); #1;
      if (i == inj) begin dv1 = 1'b0; dv3 = 1'b0; end
    end
    obs.push_back(div == 1 ? out1 : out3);
    chk_idle(div, 1'b1, {tag, ".end"});
  endtask

  task automatic send(input int div, input logic [7:0] w, input int inj, input string tag);
    chk({tag, ".ready0"}, div == 1 ? rdy1 : rdy3, 8'd1);
    if (div == 1) begin din1 = w; dv1 = 1'b1; end
    else begin din3 = w; dv3 = 1'b1; end
    @(posedge clk); #1;
    dv1 = 1'b0; dv3 = 1'b0;
    din1 = 8'($urandom); din3 = 8'($urandom);
    check_word(div, w, inj, tag);
    @(posedge clk); #1;
    chk_idle(div, 1'b0, {tag, ".after"});
  endtask

  function automatic int cnt010(input bit q[$]);
    int n = 0;
    for (int i = 2; i < q.size(); i++) if (!q[i-2] && q[i-1] && !q[i]) n++;
    return n;
  endfunction

  initial begin
    bit m[$];
    logic [7:0] w;
    int dv;
    #2;
    chk_idle(1, 1'b0, "rst1");
    chk_idle(3, 1'b0, "rst3");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    send(1, 8'hA5, -1, "a5");
    send(3, 8'h5A, -1, "5a");
    send(1, 8'h07, -1, "p07");

    // reset in the middle of 0xA5, while bit 3 is on out
    din1 = 8'hA5; dv1 = 1'b1;
    @(posedge clk); #1; dv1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst.bit3", out1, 8'd0);
    chk("midrst.busy", busy1, 8'd1);
    rst = 1'b0; #1;
    chk_idle(1, 1'b0, "midrst");
    @(negedge clk); rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; chk_idle(1, 1'b0, "postrst"); end

    // back-to-back with din_valid held high
    din1 = 8'hFF; dv1 = 1'b1;
    @(posedge clk); #1; din1 = 8'h00;
    check_word(1, 8'hFF, -1, "b2b_ff");
    @(posedge clk); #1; dv1 = 1'b0;
    check_word(1, 8'h00, -1, "b2b_00");
    @(posedge clk); #1;
    chk_idle(1, 1'b0, "b2b.after");

    send(1, 8'hC3, 3, "ign1");
    send(3, 8'h96, 10, "ign3");

    // detector chain: count 010 matches across idle-framed word
    obs.delete();
    obs.push_back(out1);
    send(1, 8'h4A, -1, "chain");
    m.push_back(1'b1);
    for (int b = 7; b >= 0; b--) m.push_back(w_bit(8'h4A, b));
`ifdef BIT_SERIALIZER_PARITY_EN
    m.push_back(^8'h4A);
`endif
    m.push_back(1'b1);
    chk("chain.matches", 8'(cnt010(obs)), 8'(cnt010(m)));
    chk("chain.len", 8'(obs.size()), 8'(m.size()));

    for (int k = 0; k < 8; k++) begin
      w = 8'($urandom);
      dv = ($urandom_range(0, 1) == 0) ? 1 : 3;
      send(dv, w, -1, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic bit w_bit(input logic [7:0] v, input int b);
    return v[b];
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
